pipeline_controller: RTL

Parametrised successor to the single-cycle control unit, for the 5-stage pipelined RV32I core.
- Decodes op/funct3/funct7b5 in Decode.
- Carries the control bundle through ID/EX, EX/MEM and MEM/WB registers, with flush support.
- Resolves branches and jumps in Execute; raises an illegal-opcode flag.
- Exposes per-stage signals for the datapath and the hazard/forward unit.

---
 rtl/pipeline_ctrl_pkg.sv | 95 +++++++++
 rtl/pipeline_controller_ctrl_decode.sv | 104 ++++++++++
 rtl/pipeline_controller.sv | 90 +++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipelined RV32I control path.
// Opcodes, select encodings, the per-stage control bundles and branch test.
package pipeline_ctrl_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } result_src_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001
    } alu_ctrl_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        mem_read;
        logic        jump;
        logic        jalr;
        logic        branch;
        logic        alu_src;
        logic        alu_src_a;
        result_src_e result_src;
        alu_ctrl_e   alu_control;
        logic [2:0]  funct3;
    } ctrl_bundle_t;

    // Memory and writeback only need the subset that is still consumed there.
    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        mem_read;
        result_src_e result_src;
    } mem_ctrl_t;

    typedef struct packed {
        logic        reg_write;
        result_src_e result_src;
    } wb_ctrl_t;

    localparam ctrl_bundle_t NOP_BUNDLE = '0;
    localparam mem_ctrl_t    NOP_MEM    = '0;
    localparam wb_ctrl_t     NOP_WB     = '0;

    function automatic logic branch_cond(
        input logic       ext,
        input logic [2:0] f3,
        input logic       zero,
        input logic       lt,
        input logic       ltu
    );
        logic c;
        c = 1'b0;
        case (f3)
            3'b000:  c = zero;
            3'b001:  c = ext & ~zero;
            3'b100:  c = ext & lt;
            3'b101:  c = ext & ~lt;
            3'b110:  c = ext & ltu;
            3'b111:  c = ext & ~ltu;
            default: c = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipeline_controller_ctrl_decode.sv
// Combinational main and ALU decode for the Decode stage.
// Unsupported opcodes yield an all-zero bundle and raise illegal.
module ctrl_decode
    import pipeline_ctrl_pkg::*;
#(
    parameter bit EXT_ISA = 1'b1
) (
    input  logic [6:0]   op,
    input  logic [2:0]   funct3,
    input  logic         funct7b5,
    output ctrl_bundle_t ctrl,
    output imm_src_e     imm_src,
    output logic         illegal
);

    logic [1:0] alu_op;

    always_comb begin
        ctrl    = NOP_BUNDLE;
        imm_src = IMM_I;
        illegal = 1'b0;
        alu_op  = 2'b00;
        unique case (1'b1)
            (op == OP_LOAD): begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.result_src = RES_MEM;
            end
            (op == OP_STORE): begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                imm_src        = IMM_S;
            end
            (op == OP_R): begin
                ctrl.reg_write = 1'b1;
                alu_op         = 2'b10;
            end
            (op == OP_I): begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                alu_op         = 2'b10;
            end
            (op == OP_BR): begin
                ctrl.branch = 1'b1;
                alu_op      = 2'b01;
                imm_src     = IMM_B;
            end
            (op == OP_JAL): begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.result_src = RES_PC4;
                imm_src         = IMM_J;
            end
            (EXT_ISA && op == OP_LUI): begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_IMM;
                imm_src         = IMM_U;
            end
            (EXT_ISA && op == OP_AUIPC): begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src   = 1'b1;
                imm_src        = IMM_U;
            end
            (EXT_ISA && op == OP_JALR): begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.jalr       = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_PC4;
            end
            default: illegal = 1'b1;
        endcase

        if (!illegal) begin
            ctrl.funct3 = funct3;
        end

        // Only R-type uses funct7b5 for sub; I-type uses it for sra only.
        case (alu_op)
            2'b01: ctrl.alu_control = ALU_SUB;
            2'b10: begin
                case (funct3)
                    3'b000: ctrl.alu_control =
                        (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010: ctrl.alu_control = ALU_SLT;
                    3'b110: ctrl.alu_control = ALU_OR;
                    3'b111: ctrl.alu_control = ALU_AND;
                    3'b001: ctrl.alu_control =
                        EXT_ISA ? ALU_SLL : ALU_ADD;
                    3'b011: ctrl.alu_control =
                        EXT_ISA ? ALU_SLTU : ALU_ADD;
                    3'b100: ctrl.alu_control =
                        EXT_ISA ? ALU_XOR : ALU_ADD;
                    default: ctrl.alu_control = !EXT_ISA ? ALU_ADD :
                        (funct7b5 ? ALU_SRA : ALU_SRL);
                endcase
            end
            default: ctrl.alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/pipeline_controller.sv
// Pipelined control unit: Decode, ID/EX, EX/MEM and MEM/WB control
// registers with flush, plus branch/jump resolution in Execute.
module pipeline_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter bit EXT_ISA   = 1'b1,
    parameter int ALUCTRL_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opD,
    input  logic [2:0]           funct3D,
    input  logic                 funct7b5D,
    input  logic                 FlushE,
    input  logic                 ZeroE,
    input  logic                 LtE,
    input  logic                 LtuE,
    output logic [2:0]           ImmSrcD,
    output logic                 IllegalD,
    output logic                 ALUSrcE,
    output logic                 ALUSrcAE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 ResultSrcE0,
    output logic                 PCSrcE,
    output logic                 JalrE,
    output logic                 RegWriteM,
    output logic                 MemWriteM,
    output logic                 MemReadM,
    output logic [1:0]           ResultSrcM,
    output logic                 RegWriteW,
    output logic [1:0]           ResultSrcW
);

    ctrl_bundle_t ctrl_d;
    imm_src_e     imm_src_d;
    ctrl_bundle_t id_ex_d,  id_ex_q;
    mem_ctrl_t    ex_mem_d, ex_mem_q;
    wb_ctrl_t     mem_wb_d, mem_wb_q;

    ctrl_decode #(
        .EXT_ISA(EXT_ISA)
    ) u_decode (
        .op      (opD),
        .funct3  (funct3D),
        .funct7b5(funct7b5D),
        .ctrl    (ctrl_d),
        .imm_src (imm_src_d),
        .illegal (IllegalD)
    );

    always_comb begin
        id_ex_d              = FlushE ? NOP_BUNDLE : ctrl_d;
        ex_mem_d             = NOP_MEM;
        ex_mem_d.reg_write   = id_ex_q.reg_write;
        ex_mem_d.mem_write   = id_ex_q.mem_write;
        ex_mem_d.mem_read    = id_ex_q.mem_read;
        ex_mem_d.result_src  = id_ex_q.result_src;
        mem_wb_d             = NOP_WB;
        mem_wb_d.reg_write   = ex_mem_q.reg_write;
        mem_wb_d.result_src  = ex_mem_q.result_src;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex_q  <= NOP_BUNDLE;
            ex_mem_q <= NOP_MEM;
            mem_wb_q <= NOP_WB;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign ImmSrcD     = imm_src_d;
    assign ALUSrcE     = id_ex_q.alu_src;
    assign ALUSrcAE    = id_ex_q.alu_src_a;
    assign ALUControlE = id_ex_q.alu_control[ALUCTRL_W-1:0];
    assign ResultSrcE0 = id_ex_q.result_src[0];
    assign JalrE       = id_ex_q.jalr;
    assign PCSrcE      = id_ex_q.jump | (id_ex_q.branch &
        branch_cond(EXT_ISA, id_ex_q.funct3, ZeroE, LtE, LtuE));
    assign RegWriteM   = ex_mem_q.reg_write;
    assign MemWriteM   = ex_mem_q.mem_write;
    assign MemReadM    = ex_mem_q.mem_read;
    assign ResultSrcM  = ex_mem_q.result_src;
    assign RegWriteW   = mem_wb_q.reg_write;
    assign ResultSrcW  = mem_wb_q.result_src;

endmodule
